// File: rtl/demux2_pair_if.sv
// Shared-bus handshake bundle for demux2_pair.
// slave: demux side (word in, pair out); master: feeder/consumer side.
interface demux2_pair_if #(
    parameter int N = 3
);
    logic         in_valid;
    logic         in_ready;
    logic         in_sel;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_a;
    logic [N-1:0] out_b;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_a, out_b
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_a, out_b
    );
endinterface

// File: rtl/demux2_pair.sv
// Rebuilds (a, b) pairs from a sel-tagged word stream, flags order errors.
// Ports: clk, rst (sync, active-high), bus (slave), err_o, err_cnt_o.
module demux2_pair #(
    parameter int N     = 3,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    demux2_pair_if.slave     bus,
    output logic             err_o,
    output logic [ERR_W-1:0] err_cnt_o
);
    localparam logic [1:0] S_A    = 2'd0;
    localparam logic [1:0] S_B    = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic             accept;

    assign bus.in_ready  = (state_q != S_FULL);
    assign bus.out_valid = (state_q == S_FULL);
    assign bus.out_a     = a_q;
    assign bus.out_b     = b_q;
    assign err_o         = err_q;
    assign err_cnt_o     = cnt_q;

    assign accept = bus.in_valid && (state_q != S_FULL);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            S_A: begin
                if (accept) begin
                    if (!bus.in_sel) begin
                        a_d     = bus.in_data;
                        state_d = S_B;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_B: begin
                if (accept) begin
                    if (bus.in_sel) begin
                        b_d     = bus.in_data;
                        state_d = S_FULL;
                    end else begin
                        // repeated a: keep the newest one
                        a_d   = bus.in_data;
                        err_d = 1'b1;
                    end
                end
            end
            S_FULL: begin
                if (bus.out_ready) begin
                    state_d = S_A;
                end
            end
            default: state_d = S_A;
        endcase
        if (err_d && (cnt_q != {ERR_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
